// File: rtl/spu_ls_pkg.sv
// -----------------------------------------------------------------------------
// spu_ls_pkg
// Shared types and constants for the local-store refill arbiter.
//   ls_line_t       : one 128-bit local-store line, big-endian bit numbering
//   refill_state_t  : refill sequencer states (IDLE, FILL, DRAIN)
//   BLOCK_LINES     : LS lines per instruction block (32 instructions)
//   LS_LINE_ADDR_W  : LS line-address width (8192 lines)
//   BEAT_W/ISSUE_W  : widths of the in-block beat index and the issued count
// -----------------------------------------------------------------------------
package spu_ls_pkg;

    localparam int BLOCK_LINES    = 8;
    localparam int LS_LINE_ADDR_W = 13;
    localparam int BEAT_W         = $clog2(BLOCK_LINES);
    localparam int ISSUE_W        = $clog2(BLOCK_LINES + 1);

    typedef logic [0:127] ls_line_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } refill_state_t;

    // Next line of a block; the beat field is exactly BEAT_W bits wide, so the
    // natural overflow gives the mod-BLOCK_LINES wrap.
    function automatic logic [BEAT_W-1:0] next_beat(input logic [BEAT_W-1:0] beat);
        return beat + BEAT_W'(1);
    endfunction

endpackage

// File: rtl/refill_beat_ctr.sv
// -----------------------------------------------------------------------------
// refill_beat_ctr
// Wrapping beat counter for an instruction-block refill plus a count of the
// beats already issued.
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-low reset
//   load       in   start a new refill: beat <= start_beat, issued <= 0
//   start_beat in   first line of the refill
//   inc        in   one refill beat is issued this cycle
//   beat       out  line index of the next beat to issue
//   issued     out  number of beats issued so far
//   last       out  the next issued beat is the final line of the block
// -----------------------------------------------------------------------------
module refill_beat_ctr
    import spu_ls_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [BEAT_W-1:0]  start_beat,
    input  logic               inc,
    output logic [BEAT_W-1:0]  beat,
    output logic [ISSUE_W-1:0] issued,
    output logic               last
);

    logic [BEAT_W-1:0]  beat_reg,   beat_next;
    logic [ISSUE_W-1:0] issued_reg, issued_next;

    always_comb begin
        beat_next   = beat_reg;
        issued_next = issued_reg;
        if (load) begin
            beat_next   = start_beat;
            issued_next = '0;
        end else if (inc) begin
            beat_next   = next_beat(beat_reg);
            issued_next = issued_reg + ISSUE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            beat_reg   <= '0;
            issued_reg <= '0;
        end else begin
            beat_reg   <= beat_next;
            issued_reg <= issued_next;
        end
    end

    assign beat   = beat_reg;
    assign issued = issued_reg;
    assign last   = (issued_reg == ISSUE_W'(BLOCK_LINES - 1));

endmodule

// File: rtl/ls_refill_arbiter.sv
// -----------------------------------------------------------------------------
// ls_refill_arbiter
// Sequences an instruction-block refill (eight LS lines) on an I-cache miss
// and shares the single LS port with the odd-pipe load/store unit.  The odd
// pipe owns the port in every cycle a refill beat is not issued; a starvation
// counter forces a refill beat after STARVE_MAX consecutive odd-pipe grants.
//
// Build option: define REFILL_CRITICAL_FIRST_EN to start the refill at the
// line holding the missing instruction (miss_beat) and wrap mod 8.  Without
// it every refill starts at line 0 and miss_beat is ignored.
//
// Parameters: STARVE_MAX, LINE_W (line width), ADDR_W (LS line-address width)
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   miss_req/miss_blk/miss_beat     I-cache miss request (held until miss_ack)
//   miss_ack, busy                  refill complete pulse, refill in progress
//   fill_valid/fill_beat/fill_last/fill_data   refill line stream
//   ls_req/ls_wr/ls_addr/ls_wdata   odd-pipe access request
//   ls_gnt                          combinational grant (issued this cycle)
//   ls_rvalid/ls_rdata              odd-pipe load return, one cycle after grant
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata   LS port (read data one cycle
//                                   after a read strobe)
// The LS strobes are driven in the cycle the access is issued so that a read
// returns one cycle later; the return tag and all status outputs are flops,
// and the returned data is mem_rdata gated by the registered tag.
// -----------------------------------------------------------------------------
module ls_refill_arbiter
    import spu_ls_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int LINE_W     = 128,
    parameter int ADDR_W     = LS_LINE_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss_req,
    input  logic [9:0]        miss_blk,
    input  logic [2:0]        miss_beat,
    output logic              miss_ack,
    output logic              busy,
    output logic              fill_valid,
    output logic [2:0]        fill_beat,
    output logic              fill_last,
    output logic [LINE_W-1:0] fill_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [0:31]       ls_addr,
    input  logic [LINE_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [LINE_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    refill_state_t       state_reg, state_next;
    logic [9:0]          blk_reg, blk_next;
    logic [STARVE_W-1:0] starve_reg, starve_next;

    // Return tag: which requester owns the data coming back on mem_rdata.
    logic                fill_tag_reg;
    logic [BEAT_W-1:0]   fill_beat_reg;
    logic                fill_last_reg;
    logic                ls_tag_reg;

    logic                accept;
    logic                issue;
    logic                gnt;
    logic                refill_win;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   start_beat;
    logic [ISSUE_W-1:0]  issued;
    logic                last_beat;
    logic [ADDR_W-1:0]   ls_line;

    assign ls_line = ADDR_W'(ls_addr[15:27]);

`ifdef REFILL_CRITICAL_FIRST_EN
    assign start_beat = miss_beat;
`else
    assign start_beat = '0;
`endif

    refill_beat_ctr u_beat_ctr (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .start_beat (start_beat),
        .inc        (issue),
        .beat       (beat),
        .issued     (issued),
        .last       (last_beat)
    );

    // ---------------------------------------------------------------------
    // Next state, arbitration and LS port strobes
    // ---------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        blk_next    = blk_reg;
        starve_next = starve_reg;
        accept      = 1'b0;
        issue       = 1'b0;
        gnt         = 1'b0;
        refill_win  = 1'b0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        case (state_reg)
            IDLE: begin
                gnt = ls_req;
                if (miss_req) begin
                    accept      = 1'b1;
                    state_next  = FILL;
                    blk_next    = miss_blk;
                    starve_next = '0;
                end
            end
            FILL: begin
                // A refill beat goes out whenever the port is free, or when
                // the odd pipe has held it for STARVE_MAX cycles in a row.
                refill_win = !ls_req || (starve_reg == STARVE_W'(STARVE_MAX));
                if (refill_win) begin
                    issue       = 1'b1;
                    starve_next = '0;
                    if (last_beat) begin
                        state_next = DRAIN;
                    end
                end else begin
                    gnt = 1'b1;
                    if (starve_reg != STARVE_W'(STARVE_MAX)) begin
                        starve_next = starve_reg + STARVE_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Only the final refill line is still returning; the port
                // itself is free for the odd pipe.
                gnt        = ls_req;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (issue) begin
            mem_en   = 1'b1;
            mem_addr = ADDR_W'({blk_reg, beat});
        end else if (gnt) begin
            mem_en    = 1'b1;
            mem_wr    = ls_wr;
            mem_addr  = ls_line;
            mem_wdata = ls_wr ? ls_wdata : '0;
        end
    end

    // ---------------------------------------------------------------------
    // State and return-tag registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            blk_reg       <= '0;
            starve_reg    <= '0;
            fill_tag_reg  <= 1'b0;
            fill_beat_reg <= '0;
            fill_last_reg <= 1'b0;
            ls_tag_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            blk_reg       <= blk_next;
            starve_reg    <= starve_next;
            fill_tag_reg  <= issue;
            if (issue) begin
                fill_beat_reg <= beat;
            end
            fill_last_reg <= issue && last_beat;
            ls_tag_reg    <= gnt && !ls_wr;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign ls_gnt     = gnt;
    assign busy       = (state_reg != IDLE);
    assign fill_valid = fill_tag_reg;
    assign fill_beat  = fill_beat_reg;
    assign fill_last  = fill_last_reg;
    assign miss_ack   = fill_last_reg;
    assign ls_rvalid  = ls_tag_reg;

    // Refill and odd-pipe returns never share a cycle, so mem_rdata is simply
    // steered by the tag; an untagged return reads as zero.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_W; gi++) begin : g_route
            assign fill_data[gi] = fill_tag_reg & mem_rdata[gi];
            assign ls_rdata[gi]  = ls_tag_reg   & mem_rdata[gi];
        end
    endgenerate

    // Address bits outside the line field, the issued count and (in the
    // default build) miss_beat are intentionally not consumed.
    logic unused_inputs;
    assign unused_inputs = ^{miss_beat, ls_addr[0:14], ls_addr[28:31], issued};

endmodule

// File: tb/tb_ls_refill_arbiter.sv
`timescale 1ns/1ps
module tb_ls_refill_arbiter;

    localparam int SM = 4;
    localparam int LW = 128;
    localparam int AW = 13;
`ifdef REFILL_CRITICAL_FIRST_EN
    localparam bit CF = 1'b1;
`else
    localparam bit CF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, miss_req;
    logic [9:0]    miss_blk;
    logic [2:0]    miss_beat;
    logic          miss_ack, busy, fill_valid, fill_last;
    logic [2:0]    fill_beat;
    logic [LW-1:0] fill_data;
    logic          ls_req, ls_wr;
    logic [0:31]   ls_addr;
    logic [LW-1:0] ls_wdata;
    logic          ls_gnt, ls_rvalid;
    logic [LW-1:0] ls_rdata;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_wdata, mem_rdata;

    ls_refill_arbiter #(.STARVE_MAX(SM), .LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .miss_req(miss_req), .miss_blk(miss_blk), .miss_beat(miss_beat),
        .miss_ack(miss_ack), .busy(busy),
        .fill_valid(fill_valid), .fill_beat(fill_beat), .fill_last(fill_last), .fill_data(fill_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Local store: synchronous single-port RAM
    logic [LW-1:0] ram [0:8191];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model state
    logic [LW-1:0] shadow [0:8191];
    int m_mode;      // 0 idle, 1 filling, 2 draining
    int m_blk, m_beat, m_issued, m_starve;
    bit e_fv, e_last, e_lv;
    int e_fbeat;
    logic [LW-1:0] e_fdata, e_ldata;

    int n_checks, n_fail;
    bit chk_en;

    // Observations from the most recent step (sampled at negedge)
    logic o_gnt, o_mem_en, o_busy, o_fv, o_flast, o_ack, o_rv;
    int   o_mem_addr, o_fbeat;
    logic [LW-1:0] o_fdata, o_ldata;

    function automatic logic [LW-1:0] line_data(input int a);
        logic [15:0] w;
        w = {3'b101, 13'(a)};
        return {8{w}};
    endfunction

    function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic step();
        bit e_gnt, e_iss;
        int line;
        @(negedge clk);
        line  = int'(ls_addr[15:27]);
        e_gnt = (m_mode == 1) ? (ls_req && (m_starve != SM)) : ls_req;
        e_iss = (m_mode == 1) && !e_gnt;
        if (chk_en) begin
            chk("ls_gnt", LW'(ls_gnt), LW'(e_gnt));
            chk("mem_en", LW'(mem_en), LW'(e_gnt || e_iss));
            if (e_iss) begin
                chk("refill_mem_wr", LW'(mem_wr), '0);
                chk("refill_addr", LW'(mem_addr), LW'(m_blk * 8 + m_beat));
            end
            if (e_gnt) begin
                chk("ls_mem_wr", LW'(mem_wr), LW'(ls_wr));
                chk("ls_mem_addr", LW'(mem_addr), LW'(line));
                if (ls_wr) chk("ls_wdata", mem_wdata, ls_wdata);
            end
            chk("busy", LW'(busy), LW'(m_mode != 0));
            chk("fill_valid", LW'(fill_valid), LW'(e_fv));
            if (e_fv) begin
                chk("fill_beat", LW'(fill_beat), LW'(e_fbeat));
                chk("fill_data", fill_data, e_fdata);
            end
            chk("fill_last", LW'(fill_last), LW'(e_last));
            chk("miss_ack", LW'(miss_ack), LW'(e_last));
            chk("ls_rvalid", LW'(ls_rvalid), LW'(e_lv));
            if (e_lv) chk("ls_rdata", ls_rdata, e_ldata);
        end
        o_gnt = ls_gnt; o_mem_en = mem_en; o_mem_addr = int'(mem_addr); o_busy = busy;
        o_fv = fill_valid; o_fbeat = int'(fill_beat); o_flast = fill_last; o_ack = miss_ack;
        o_rv = ls_rvalid; o_fdata = fill_data; o_ldata = ls_rdata;
        @(posedge clk);
        e_fv   = e_iss;
        if (e_iss) begin
            e_fbeat = m_beat;
            e_fdata = shadow[m_blk * 8 + m_beat];
        end
        e_last = e_iss && (m_issued == 7);
        e_lv   = e_gnt && !ls_wr;
        if (e_lv) e_ldata = shadow[line];
        if (e_gnt && ls_wr) shadow[line] = ls_wdata;
        if (!reset) begin
            m_mode = 0; m_starve = 0; e_fv = 0; e_last = 0; e_lv = 0;
        end else begin
            case (m_mode)
                0: if (miss_req) begin
                    m_mode = 1; m_blk = int'(miss_blk);
                    m_beat = CF ? int'(miss_beat) : 0;
                    m_issued = 0; m_starve = 0;
                end
                1: if (e_iss) begin
                    m_beat = (m_beat + 1) % 8; m_issued++; m_starve = 0;
                    if (m_issued == 8) m_mode = 2;
                end else begin
                    m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
                end
                default: m_mode = 0;
            endcase
        end
        #1;
    endtask

    // Per-miss records (cycle numbers relative to the acceptance edge 0)
    int ack_cyc, gnt0_cnt, last_fbeat;
    int iss_cyc[$], iss_addr[$], fv_cyc[$], fb_seq[$];

    task automatic run_miss(input int blk, input int beat, input bit contend, input bit keep);
        ack_cyc = -1; gnt0_cnt = 0; last_fbeat = -1;
        iss_cyc.delete(); iss_addr.delete(); fv_cyc.delete(); fb_seq.delete();
        miss_req = 1'b1; miss_blk = 10'(blk); miss_beat = 3'(beat); ls_req = 1'b0;
        step();
        for (int c = 1; c <= 100; c++) begin
            ls_req = contend; ls_wr = 1'b0; ls_addr = 32'h0000_0040;
            step();
            if (o_mem_en && !o_gnt) begin iss_cyc.push_back(c); iss_addr.push_back(o_mem_addr); end
            if (o_fv) begin fv_cyc.push_back(c); fb_seq.push_back(o_fbeat); end
            if (o_busy && !o_gnt && contend) gnt0_cnt++;
            if (o_ack) begin
                ack_cyc = c; last_fbeat = o_fbeat;
                if (!keep) miss_req = 1'b0;
                break;
            end
        end
        ls_req = 1'b0;
        if (ack_cyc < 0) begin
            n_checks++; n_fail++;
            $display("FAIL miss_ack_timeout: got none expected within 100 cycles");
        end
    endtask

    typedef struct {
        logic          req;
        logic          wr;
        logic [31:0]   addr;
        logic [LW-1:0] wdata;
        logic          exp_gnt;
        logic          exp_rv;      // rvalid in this row's cycle
        logic [LW-1:0] exp_rdata;
    } vec_t;
    vec_t vecs[9];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] aa, fives;
        bit pend;
        int start;
        aa    = {16{8'hAA}};
        fives = {16{8'h55}};
        vecs[0] = '{1'b1, 1'b1, 32'h40,   aa,    1'b1, 1'b0, '0};
        vecs[1] = '{1'b1, 1'b0, 32'h40,   '0,    1'b1, 1'b0, '0};
        vecs[2] = '{1'b0, 1'b0, 32'h0,    '0,    1'b0, 1'b1, aa};
        vecs[3] = '{1'b1, 1'b1, 32'h50,   fives, 1'b1, 1'b0, '0};
        vecs[4] = '{1'b1, 1'b0, 32'h50,   '0,    1'b1, 1'b0, '0};
        vecs[5] = '{1'b1, 1'b0, 32'h40,   '0,    1'b1, 1'b1, fives};
        vecs[6] = '{1'b0, 1'b0, 32'h0,    '0,    1'b0, 1'b1, aa};
        vecs[7] = '{1'b1, 1'b0, 32'h1230, '0,    1'b1, 1'b0, '0};
        vecs[8] = '{1'b0, 1'b0, 32'h0,    '0,    1'b0, 1'b1, line_data(32'h123)};

        n_checks = 0; n_fail = 0; chk_en = 1'b0;
        for (int a = 0; a < 8192; a++) begin ram[a] = line_data(a); shadow[a] = line_data(a); end
        m_mode = 0; m_blk = 0; m_beat = 0; m_issued = 0; m_starve = 0;
        e_fv = 0; e_last = 0; e_lv = 0; e_fbeat = 0; e_fdata = '0; e_ldata = '0;
        reset = 1'b0; miss_req = 1'b0; miss_blk = '0; miss_beat = '0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_wdata = '0;
        step(); step();
        chk_en = 1'b1;

        // Reset state
        step();
        chk("rst_busy", LW'(o_busy), '0);
        chk("rst_fill_beat", LW'(o_fbeat), '0);
        chk("rst_fill_data", o_fdata, '0);
        chk("rst_ls_rdata", o_ldata, '0);
        reset = 1'b1;

        // Odd-pipe traffic in IDLE
        for (int i = 0; i < 9; i++) begin
            ls_req = vecs[i].req; ls_wr = vecs[i].wr; ls_addr = vecs[i].addr; ls_wdata = vecs[i].wdata;
            step();
            chk("tbl_gnt", LW'(o_gnt), LW'(vecs[i].exp_gnt));
            chk("tbl_rvalid", LW'(o_rv), LW'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) chk("tbl_rdata", o_ldata, vecs[i].exp_rdata);
        end
        ls_req = 1'b0;
        step();

        // Uncontended refill of block 3
        run_miss(3, 0, 1'b0, 1'b0);
        chk("unc_ack_cycle", LW'(ack_cyc), LW'(9));
        chk("unc_n_issue", LW'(iss_cyc.size()), LW'(8));
        chk("unc_n_fill", LW'(fv_cyc.size()), LW'(8));
        for (int i = 0; i < 8 && i < iss_cyc.size(); i++) begin
            chk("unc_issue_cycle", LW'(iss_cyc[i]), LW'(i + 1));
            chk("unc_issue_addr", LW'(iss_addr[i]), LW'(32'h18 + i));
        end
        for (int i = 0; i < 8 && i < fv_cyc.size(); i++)
            chk("unc_fill_cycle", LW'(fv_cyc[i]), LW'(i + 2));
        step();
        chk("unc_idle_c10", LW'(o_busy), '0);

        // Starvation: odd pipe requests every cycle
        run_miss(7, 0, 1'b1, 1'b0);
        chk("starve_ack_cycle", LW'(ack_cyc), LW'(9 + 8 * SM));
        chk("starve_gnt0_count", LW'(gnt0_cnt), LW'(8));
        for (int i = 0; i < 8 && i < iss_cyc.size(); i++)
            chk("starve_issue_cycle", LW'(iss_cyc[i]), LW'((SM + 1) * (i + 1)));
        step();

        // Start beat: critical-first when enabled, else line 0
        run_miss(10'h2A, 5, 1'b0, 1'b0);
        start = CF ? 5 : 0;
        chk("cf_n_fill", LW'(fb_seq.size()), LW'(8));
        for (int i = 0; i < 8 && i < fb_seq.size(); i++)
            chk("cf_fill_beat", LW'(fb_seq[i]), LW'((start + i) % 8));
        chk("cf_last_beat", LW'(last_fbeat), LW'((start + 7) % 8));
        step();

        // Reset after three beats
        miss_req = 1'b1; miss_blk = 10'h011; miss_beat = 3'd2;
        step();
        for (int c = 1; c <= 3; c++) step();
        miss_req = 1'b0; reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("rstmid_busy", LW'(o_busy), '0);
        chk("rstmid_fill_valid", LW'(o_fv), '0);
        chk("rstmid_miss_ack", LW'(o_ack), '0);
        run_miss(10'h011, 2, 1'b0, 1'b0);
        start = CF ? 2 : 0;
        if (iss_addr.size() > 0) chk("rstmid_restart_addr", LW'(iss_addr[0]), LW'(32'h11 * 8 + start));
        step();

        // Back-to-back misses
        run_miss(10'h020, 0, 1'b0, 1'b1);
        chk("b2b_ack_cycle", LW'(ack_cyc), LW'(9));
        miss_blk = 10'h021; miss_beat = 3'd0;
        step();
        miss_req = 1'b0;
        step();
        chk("b2b_first_issue_en", LW'(o_mem_en), LW'(1));
        chk("b2b_first_issue_addr", LW'(o_mem_addr), LW'(32'h108));
        ack_cyc = -1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (o_ack) begin ack_cyc = c; break; end
        end
        chk("b2b_second_ack_seen", LW'(ack_cyc >= 0), LW'(1));
        step();

        // Randomized traffic against the model
        pend = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!pend && $urandom_range(0, 7) == 0) begin
                pend = 1'b1; miss_req = 1'b1;
                miss_blk = 10'($urandom_range(0, 3)); miss_beat = 3'($urandom_range(0, 7));
            end
            ls_req   = ($urandom_range(0, 2) != 0);
            ls_wr    = ($urandom_range(0, 2) == 0);
            ls_addr  = 32'($urandom_range(0, 47)) << 4;
            ls_wdata = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (o_ack) begin pend = 1'b0; miss_req = 1'b0; end
        end
        ls_req = 1'b0; miss_req = 1'b0;
        repeat (50) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
